// File: rtl/mtm_alu_pkg.sv
// Shared constants for the MTM ALU controller: opcodes, flag positions, CRC-3 polynomial,
// the timeout error byte and the controller state encoding.
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Bit positions inside the {carry, overflow, zero, negative} flag nibble
  localparam int unsigned FLAG_NEG   = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_CARRY = 3;

  // x^3 + x + 1 with the implicit x^3 term dropped
  localparam logic [2:0] CRC3_POLY = 3'b011;

  localparam logic [7:0] ERR_CTL_TIMEOUT = 8'b1000_0110;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIssue   = 3'd1;
  localparam logic [2:0] StWaitAlu = 3'd2;
  localparam logic [2:0] StResp    = 3'd3;
  localparam logic [2:0] StSend    = 3'd4;

endpackage

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC-3 (x^3+x+1, init 000, MSB first) over a Width-bit word.
module mtm_alu_crc3
  import mtm_alu_pkg::*;
#(
  parameter int unsigned Width = 37
) (
  input  logic [Width-1:0] data_i,
  output logic [2:0]       crc_o
);

  logic [2:0] crc;
  logic       fb;

  always_comb begin
    crc = 3'b000;
    fb  = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      fb  = crc[2] ^ data_i[i];
      crc = {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
    end
    crc_o = crc;
  end

endmodule

// File: rtl/mtm_alu_ctrl.sv
// Sequencer between deserializer, ALU core and serializer. Define MTM_ALU_CTRL_TIMEOUT_EN
// to abort a WAIT_ALU that lasts TIMEOUT_CYC cycles with an error CTL byte.
module mtm_alu_ctrl
  import mtm_alu_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] A_in,
  input  logic [DATA_W-1:0] B_in,
  input  logic [2:0]        OP_in,
  input  logic [7:0]        in_ctl,
  output logic              in_busy,
  output logic              overrun,
  output logic              alu_start,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [2:0]        alu_op,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_is_ctl,
  output logic [DATA_W-1:0] tx_data,
  output logic [7:0]        tx_ctl
);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic [3:0]        flags_q, flags_d;
  logic [7:0]        ctl_q, ctl_d;
  logic              is_ctl_q, is_ctl_d;
  logic              overrun_q, overrun_d;
  logic [2:0]        crc;

  mtm_alu_crc3 #(
    .Width (DATA_W + 5)
  ) u_crc3 (
    .data_i ({res_q, 1'b0, flags_q}),
    .crc_o  (crc)
  );

`ifdef MTM_ALU_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_hit;
  assign tmo_hit = (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    flags_d   = flags_q;
    ctl_d     = ctl_q;
    is_ctl_d  = is_ctl_q;
    // Any request outside IDLE is dropped and remembered until reset
    overrun_d = overrun_q | ((in_valid | in_err) & (state_q != StIdle));
`ifdef MTM_ALU_CTRL_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_err) begin
          ctl_d    = in_ctl;
          is_ctl_d = 1'b1;
          state_d  = StSend;
        end else if (in_valid) begin
          a_d     = A_in;
          b_d     = B_in;
          op_d    = OP_in;
          state_d = StIssue;
        end
      end
      StIssue: begin
`ifdef MTM_ALU_CTRL_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = StWaitAlu;
      end
      StWaitAlu: begin
        if (alu_done) begin
          res_d   = alu_result;
          flags_d = alu_flags;
          state_d = StResp;
`ifdef MTM_ALU_CTRL_TIMEOUT_EN
        end else if (tmo_hit) begin
          ctl_d    = ERR_CTL_TIMEOUT;
          is_ctl_d = 1'b1;
          state_d  = StSend;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        ctl_d    = {1'b0, flags_q, crc};
        is_ctl_d = 1'b0;
        state_d  = StSend;
      end
      StSend: begin
        if (tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      ctl_q     <= '0;
      is_ctl_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      ctl_q     <= ctl_d;
      is_ctl_q  <= is_ctl_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef MTM_ALU_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  assign in_busy   = (state_q != StIdle);
  assign alu_start = (state_q == StIssue);
  assign tx_valid  = (state_q == StSend);
  assign overrun   = overrun_q;
  assign alu_A     = a_q;
  assign alu_B     = b_q;
  assign alu_op    = op_q;
  assign tx_data   = res_q;
  assign tx_ctl    = ctl_q;
  assign tx_is_ctl = is_ctl_q;

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Directed, table-driven bench for mtm_alu_ctrl; timeout cases run when
// MTM_ALU_CTRL_TIMEOUT_EN is defined.
module tb_mtm_alu_ctrl;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_err = 1'b0;
  logic [DW-1:0] A_in = '0, B_in = '0;
  logic [2:0]    OP_in = '0;
  logic [7:0]    in_ctl = '0;
  logic          in_busy, overrun, alu_start;
  logic [DW-1:0] alu_A, alu_B;
  logic [2:0]    alu_op;
  logic          alu_done = 1'b0;
  logic [DW-1:0] alu_result = '0;
  logic [3:0]    alu_flags = '0;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          tx_is_ctl;
  logic [DW-1:0] tx_data;
  logic [7:0]    tx_ctl;

  int n_tests = 0;
  int n_fail  = 0;

  mtm_alu_ctrl #(
    .DATA_W      (DW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_err     (in_err),
    .A_in       (A_in),
    .B_in       (B_in),
    .OP_in      (OP_in),
    .in_ctl     (in_ctl),
    .in_busy    (in_busy),
    .overrun    (overrun),
    .alu_start  (alu_start),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_is_ctl  (tx_is_ctl),
    .tx_data    (tx_data),
    .tx_ctl     (tx_ctl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op;
    logic [DW-1:0] res;
    logic [3:0]    flags;
    int            dly;
    logic [7:0]    ctl;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Remainder of {data, 000} divided by 1011
  function automatic logic [2:0] crc3_ref(input logic [36:0] d);
    logic [39:0] m;
    m = {d, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (m[i]) m[i-:4] = m[i-:4] ^ 4'b1011;
    return m[2:0];
  endfunction

  function automatic vec_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [2:0] op, input logic [DW-1:0] res,
                              input logic [3:0] flags, input int dly);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res; v.flags = flags; v.dly = dly;
    v.ctl = {1'b0, flags, crc3_ref({res, 1'b0, flags})};
    return v;
  endfunction

  // One full operation; hold = cycles the serializer stalls in SEND
  task automatic run_op(input vec_t v, input int hold);
    tx_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b1; A_in = v.a; B_in = v.b; OP_in = v.op;
    @(negedge clk);
    in_valid = 1'b0; A_in = ~v.a; B_in = ~v.b; OP_in = ~v.op;
    chk("alu_start_pulse", 64'(alu_start), 64'(1));
    chk("alu_A", 64'(alu_A), 64'(v.a));
    chk("alu_B", 64'(alu_B), 64'(v.b));
    chk("alu_op", 64'(alu_op), 64'(v.op));
    @(negedge clk);
    chk("alu_start_single", 64'(alu_start), 64'(0));
    chk("busy_wait", 64'(in_busy), 64'(1));
    repeat (v.dly) @(negedge clk);
    alu_done = 1'b1; alu_result = v.res; alu_flags = v.flags;
    @(negedge clk);
    alu_done = 1'b0; alu_result = 32'h5A5A_5A5A; alu_flags = 4'hF;
    chk("tx_valid_in_resp", 64'(tx_valid), 64'(0));
    @(negedge clk);
    chk("tx_valid", 64'(tx_valid), 64'(1));
    chk("tx_data", 64'(tx_data), 64'(v.res));
    chk("tx_ctl", 64'(tx_ctl), 64'(v.ctl));
    chk("tx_is_ctl", 64'(tx_is_ctl), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(tx_valid), 64'(1));
      chk("hold_data_ctl", {24'h0, tx_ctl, tx_data}, {24'h0, v.ctl, v.res});
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("tx_valid_drop", 64'(tx_valid), 64'(0));
    chk("busy_idle", 64'(in_busy), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(32'h0000_0001, 32'h0000_0002, 3'b100, 32'h0000_0003, 4'b0000, 3);
    vecs[0].ctl = 8'h06;
    vecs[1] = mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 4'b0000, 0);
    vecs[2] = mk(32'h1234_0000, 32'h0000_5678, 3'b001, 32'h1234_5678, 4'b0000, 1);
    vecs[3] = mk(32'h0000_0005, 32'h0000_0005, 3'b101, 32'h0000_0000, 4'b0010, 2);
    vecs[4] = mk(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 32'h0000_0000, 4'b1010, 5);
    vecs[5] = mk(32'h0000_0000, 32'h0000_0001, 3'b101, 32'hFFFF_FFFF, 4'b1001, 4);
    vecs[6] = mk(32'hCAFE_0000, 32'h0000_BABE, 3'b111, 32'hDEAD_BEEF, 4'b0101, 2);

    #2 rst = 1'b0;
    #1;
    chk("rst_busy", 64'(in_busy), 64'(0));
    chk("rst_outs", {58'h0, overrun, alu_start, tx_valid, tx_is_ctl, 2'b00}, 64'h0);
    chk("rst_regs", {alu_A, alu_B}, 64'h0);
    chk("rst_tx", {21'h0, alu_op, tx_ctl, tx_data}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_op(vecs[i], 0);

    // Back-pressure: serializer stalls for 10 cycles
    run_op(vecs[2], 10);

    // Error frame goes straight to SEND without touching the ALU
    tx_ready = 1'b0;
    @(negedge clk);
    in_err = 1'b1; in_ctl = 8'hC9;
    @(negedge clk);
    in_err = 1'b0; in_ctl = 8'h00;
    chk("err_valid", 64'(tx_valid), 64'(1));
    chk("err_is_ctl", 64'(tx_is_ctl), 64'(1));
    chk("err_ctl", 64'(tx_ctl), 64'hC9);
    chk("err_no_start", 64'(alu_start), 64'(0));
    tx_ready = 1'b1;
    @(negedge clk);
    chk("err_drop", 64'(tx_valid), 64'(0));
    chk("err_no_start2", 64'(alu_start), 64'(0));

    // Collision: in_err beats in_valid, operands discarded
    @(negedge clk);
    in_err = 1'b1; in_valid = 1'b1; in_ctl = 8'hA5; A_in = 32'h1111_1111; OP_in = 3'b100;
    @(negedge clk);
    in_err = 1'b0; in_valid = 1'b0;
    chk("col_valid", 64'(tx_valid), 64'(1));
    chk("col_is_ctl", 64'(tx_is_ctl), 64'(1));
    chk("col_ctl", 64'(tx_ctl), 64'hA5);
    chk("col_no_start", 64'(alu_start), 64'(0));
    chk("col_A_kept", 64'(alu_A), 64'(vecs[2].a));
    @(negedge clk);
    chk("col_idle", {62'h0, in_busy, alu_start}, 64'h0);
    chk("col_no_overrun", 64'(overrun), 64'(0));

    // Overrun: request during WAIT_ALU is dropped, current op completes
    @(negedge clk);
    in_valid = 1'b1; A_in = 32'h7; B_in = 32'h8; OP_in = 3'b100;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ovr_start", 64'(alu_start), 64'(1));
    @(negedge clk);
    in_valid = 1'b1; A_in = 32'h99; B_in = 32'h77; OP_in = 3'b001;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ovr_set", 64'(overrun), 64'(1));
    chk("ovr_A_kept", 64'(alu_A), 64'h7);
    chk("ovr_op_kept", 64'(alu_op), 64'(3'b100));
    alu_done = 1'b1; alu_result = 32'hF; alu_flags = 4'b0000;
    @(negedge clk);
    alu_done = 1'b0;
    @(negedge clk);
    chk("ovr_tx_data", 64'(tx_data), 64'hF);
    chk("ovr_tx_ctl", 64'(tx_ctl), 64'({1'b0, 4'b0000, crc3_ref({32'hF, 1'b0, 4'b0000})}));
    @(negedge clk);
    chk("ovr_sticky", 64'(overrun), 64'(1));
    chk("ovr_no_restart", 64'(alu_start), 64'(0));

    // Asynchronous reset in WAIT_ALU, then a stale alu_done
    @(negedge clk);
    in_valid = 1'b1; A_in = 32'hABCD; B_in = 32'h1234; OP_in = 3'b101;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_flags", {59'h0, in_busy, overrun, alu_start, tx_valid, tx_is_ctl}, 64'h0);
    chk("arst_ops", {alu_A, alu_B}, 64'h0);
    chk("arst_tx", {21'h0, alu_op, tx_ctl, tx_data}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    alu_done = 1'b1; alu_result = 32'h4321; alu_flags = 4'b1111;
    @(negedge clk);
    alu_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_done_ignored", {61'h0, tx_valid, in_busy, alu_start}, 64'h0);
    end
    chk("late_done_data", 64'(tx_data), 64'h0);

`ifdef MTM_ALU_CTRL_TIMEOUT_EN
    // No alu_done for 16 WAIT_ALU cycles
    @(negedge clk);
    in_valid = 1'b1; A_in = 32'h1; B_in = 32'h1; OP_in = 3'b100;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    repeat (15) @(negedge clk);
    chk("tmo_not_yet", 64'(tx_valid), 64'(0));
    @(negedge clk);
    chk("tmo_valid", 64'(tx_valid), 64'(1));
    chk("tmo_ctl", 64'(tx_ctl), 64'h86);
    chk("tmo_is_ctl", 64'(tx_is_ctl), 64'(1));
    @(negedge clk);
    chk("tmo_idle", 64'(in_busy), 64'(0));

    // alu_done in the 16th cycle wins over the timeout
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    repeat (15) @(negedge clk);
    alu_done = 1'b1; alu_result = 32'h2; alu_flags = 4'b0000;
    @(negedge clk);
    alu_done = 1'b0;
    chk("tmo_done_resp", 64'(tx_valid), 64'(0));
    @(negedge clk);
    chk("tmo_done_valid", 64'(tx_valid), 64'(1));
    chk("tmo_done_is_ctl", 64'(tx_is_ctl), 64'(0));
    chk("tmo_done_ctl", 64'(tx_ctl), 64'({1'b0, 4'b0000, crc3_ref({32'h2, 1'b0, 4'b0000})}));
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
